mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Sole owner of the 8-bit external memory port.
- Shares that port between instruction fetch (IF, 4-byte reads) and the load/store buffer's data-cache requests (1/2/4-byte loads and stores).
- Serialises each transaction byte by byte and arbitrates between the two requesters round-robin.
- Holds a one-entry latch for the data side's one-cycle request pulse, and returns completed loads by nick.

Parameters:
- NICK_W, 5, width of the load/store nick tag.
- LEN_W, 3, width of the length field; the encoding is the byte count (1, 2 or 4).
- IO_HI, 2'b11, value of addr[17:16] that marks the memory-mapped IO window.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- rdy  in  1  global enable; when low, all state is frozen.
- clr  in  1  pipeline flush (misprediction).
- iIF_en  in  1  fetch request; a level held until oIF_en.
- iIF_addr  in  32  fetch address.
- oIF_en  out  1  fetch-done pulse.
- oIF_dt  out  32  fetched instruction word, little-endian.
- iDC_en  in  1  data request; a one-cycle pulse.
- iDC_ls  in  1  0 = load, 1 = store.
- iDC_nick  in  NICK_W  tag of the request.
- iDC_len  in  LEN_W  byte count.
- iDC_addr  in  32  byte address.
- iDC_dt  in  32  store data; the low iDC_len bytes are used.
- oDC_busy  out  1  data latch occupied; the requester must not pulse iDC_en while this is high.
- oDC_en  out  1  load-done pulse.
- oDC_nick  out  NICK_W  tag of the completed load.
- oDC_dt  out  32  load data, zero-extended (sign extension is done downstream).
- mem_din  in  8  memory read byte.
- mem_dout  out  8  memory write byte.
- mem_a  out  32  memory byte address.
- mem_wr  out  1  1 = write this cycle.
- io_buffer_full  in  1  IO output FIFO is full.

Behaviour:
- Reset (async, rst=1):
  - state = IDLE, data latch empty, last_grant = DC.
  - All outputs are 0: mem_a = 0, mem_wr = 0, mem_dout = 0, oIF_en = 0, oDC_en = 0, oDC_busy = 0, data outputs 0.
  - Reset mid-transaction aborts it; no done pulse is issued.
- rdy=0: nothing advances, mem_wr is forced to 0, and mem_a holds its value.
- Data latch:
  - iDC_en captures {ls, nick, len, addr, dt} on the next edge.
  - oDC_busy goes high from the next cycle until the latched request completes (the cycle after the final byte is issued or captured).
  - An iDC_en pulse while busy is a protocol error; it is ignored and flagged by an assertion.
- States: IDLE, READ, WRITE.
- IDLE:
  - If only one requester is pending, grant it.
  - If both are pending, grant the one not equal to last_grant, then update last_grant.
  - A latched store is always granted regardless of clr.
- READ (N bytes, base address A):
  - Issue cycles c = 0..N-1 drive mem_a = A+c, mem_wr = 0.
  - mem_din in cycle c+1 is byte c, written to bits [8c+7:8c].
  - The done pulse is issued in cycle N+1 (oIF_en or oDC_en with the latched nick), then the block returns to IDLE.
  - A new grant may issue its first byte in the cycle following the done cycle.
  - IF read latency from the request edge to oIF_en is 6 cycles for 4 bytes.
- WRITE (N bytes):
  - Cycle c drives mem_a = A+c, mem_dout = dt[8c+7:8c], mem_wr = 1.
  - After byte N-1 the latch is released and the block returns to IDLE. There is no oDC_en for stores.
- IO stall: while WRITE has addr[17:16] == IO_HI and io_buffer_full = 1, the current byte is held (mem_wr = 0, same address and data, counter frozen) until full drops.
- Address arithmetic is 32-bit and wraps modulo 2^32.
- clr=1 on an edge:
  - An in-flight or pending IF read is dropped, and a latched or in-flight load is dropped. No done pulse is issued for either, state goes to IDLE, and oDC_busy goes to 0.
  - A latched or in-flight store is unaffected and completes in full.
  - If iDC_en is asserted in the same cycle as clr, it is captured only if it is a store.
- Simultaneous events:
  - Done and a new iDC_en in the same cycle is legal, because busy has already dropped.
  - An IF request that is withdrawn before grant is simply not served.

Test Plan:
- IF only, addr 0x1000, memory bytes 13,05,00,00 -> mem_a steps 0x1000..0x1003, oIF_dt = 0x00000513, oIF_en exactly one pulse, 6 cycles after the request.
- DC store len=2, addr 0x20, dt 0xAABBCCDD -> two cycles with mem_wr=1: (0x20, DD) then (0x21, CC); no oDC_en; busy drops after the second byte.
- IF and DC load (nick 3, len 1, addr 0x40, byte 0x80) pending together, last_grant=DC -> IF served first, then the load; oDC_nick = 3, oDC_dt = 0x00000080.
- Load in flight at byte 1, clr pulses -> no oDC_en, busy = 0, state IDLE; a following IF request is served normally.
- Store len=1 to 0x30000 with io_buffer_full=1 for 3 cycles -> mem_wr stays 0 for 3 cycles, then one write of that byte; clr during the stall does not cancel it.
- rst asserted asynchronously mid-READ -> all outputs are 0 immediately, no done pulse; after release, requests are served from IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: sole owner of the byte-wide external memory port, serialising
// instruction fetches and load/store requests round-robin, one byte per cycle.
module mem_arbiter #(
  parameter int unsigned NICK_W = 5,
  parameter int unsigned LEN_W  = 3,
  parameter logic [1:0]  IO_HI  = 2'b11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clr,
  input  logic              iIF_en,
  input  logic [31:0]       iIF_addr,
  output logic              oIF_en,
  output logic [31:0]       oIF_dt,
  input  logic              iDC_en,
  input  logic              iDC_ls,
  input  logic [NICK_W-1:0] iDC_nick,
  input  logic [LEN_W-1:0]  iDC_len,
  input  logic [31:0]       iDC_addr,
  input  logic [31:0]       iDC_dt,
  output logic              oDC_busy,
  output logic              oDC_en,
  output logic [NICK_W-1:0] oDC_nick,
  output logic [31:0]       oDC_dt,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [31:0]       mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_READ = 2'd1, S_WRITE = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d, len_q, len_d;
  logic              own_dc_q, own_dc_d, last_dc_q, last_dc_d;
  logic              lat_v_q, lat_v_d, lat_ls_q, lat_ls_d;
  logic [NICK_W-1:0] lat_nick_q, lat_nick_d;
  logic [LEN_W-1:0]  lat_len_q, lat_len_d;
  logic [31:0]       lat_addr_q, lat_addr_d, lat_dt_q, lat_dt_d;
  logic [31:0]       rdata_q, rdata_d, mem_a_q, mem_a_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              mem_wr_q, mem_wr_d;
  logic              oif_en_q, oif_en_d, odc_en_q, odc_en_d;
  logic [31:0]       oif_dt_q, oif_dt_d, odc_dt_q, odc_dt_d;
  logic [NICK_W-1:0] odc_nick_q, odc_nick_d;

  logic              if_pend_s, dc_pend_s, grant_dc_s, stall_s;
  logic [LEN_W-1:0]  nxt_s, cap_idx_s;
  logic [31:0]       rd_word_s;

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [LEN_W-1:0] idx);
    case (idx)
      LEN_W'(0): byte_sel = w[7:0];
      LEN_W'(1): byte_sel = w[15:8];
      LEN_W'(2): byte_sel = w[23:16];
      LEN_W'(3): byte_sel = w[31:24];
      default:   byte_sel = 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] byte_ins(input logic [31:0] w, input logic [LEN_W-1:0] idx,
                                           input logic [7:0] b);
    byte_ins = w;
    case (idx)
      LEN_W'(0): byte_ins[7:0]   = b;
      LEN_W'(1): byte_ins[15:8]  = b;
      LEN_W'(2): byte_ins[23:16] = b;
      LEN_W'(3): byte_ins[31:24] = b;
      default:   byte_ins        = w;
    endcase
  endfunction

  // A done pulse is still visible while the fetcher drops its level request, so mask it.
  assign if_pend_s  = iIF_en && !oif_en_q && !clr;
  assign dc_pend_s  = lat_v_q && (lat_ls_q || !clr);
  assign grant_dc_s = dc_pend_s && (!if_pend_s || !last_dc_q);
  assign stall_s    = (lat_addr_q[17:16] == IO_HI) && io_buffer_full;
  assign nxt_s      = cnt_q + LEN_W'(1);
  assign cap_idx_s  = cnt_q - LEN_W'(1);
  assign rd_word_s  = byte_ins(rdata_q, cap_idx_s, mem_din);

  // Next-state: request latch, arbitration and byte sequencing.
  always_comb begin
    state_d    = state_q;    cnt_d      = cnt_q;      len_d      = len_q;
    own_dc_d   = own_dc_q;   last_dc_d  = last_dc_q;  lat_v_d    = lat_v_q;
    lat_ls_d   = lat_ls_q;   lat_nick_d = lat_nick_q; lat_len_d  = lat_len_q;
    lat_addr_d = lat_addr_q; lat_dt_d   = lat_dt_q;   rdata_d    = rdata_q;
    mem_a_d    = mem_a_q;    mem_dout_d = mem_dout_q; mem_wr_d   = mem_wr_q;
    oif_en_d   = 1'b0;       oif_dt_d   = oif_dt_q;   odc_en_d   = 1'b0;
    odc_nick_d = odc_nick_q; odc_dt_d   = odc_dt_q;

    if (iDC_en && !lat_v_q && (!clr || iDC_ls)) begin
      lat_v_d    = 1'b1;
      lat_ls_d   = iDC_ls;
      lat_nick_d = iDC_nick;
      lat_len_d  = iDC_len;
      lat_addr_d = iDC_addr;
      lat_dt_d   = iDC_dt;
    end else if (clr && lat_v_q && !lat_ls_q) begin
      lat_v_d = 1'b0;
    end else begin
      lat_v_d = lat_v_q;
    end

    case (state_q)
      S_IDLE: begin
        if (grant_dc_s) begin
          own_dc_d  = 1'b1;
          last_dc_d = 1'b1;
          len_d     = lat_len_q;
          cnt_d     = LEN_W'(0);
          mem_a_d   = lat_addr_q;
          rdata_d   = 32'h0000_0000;
          if (lat_ls_q) begin
            state_d    = S_WRITE;
            mem_dout_d = lat_dt_q[7:0];
            mem_wr_d   = !stall_s;
          end else begin
            state_d = S_READ;
          end
        end else if (if_pend_s) begin
          state_d   = S_READ;
          own_dc_d  = 1'b0;
          last_dc_d = 1'b0;
          len_d     = LEN_W'(4);
          cnt_d     = LEN_W'(0);
          mem_a_d   = iIF_addr;
          rdata_d   = 32'h0000_0000;
        end else begin
          state_d = S_IDLE;
        end
      end
      // cnt_q is the byte being issued; the byte returned now belongs to cnt_q-1.
      S_READ: begin
        if (clr) begin
          state_d = S_IDLE;
        end else if (cnt_q == len_q) begin
          state_d = S_IDLE;
          if (own_dc_q) begin
            odc_en_d   = 1'b1;
            odc_nick_d = lat_nick_q;
            odc_dt_d   = rd_word_s;
            lat_v_d    = 1'b0;
          end else begin
            oif_en_d = 1'b1;
            oif_dt_d = rd_word_s;
          end
        end else begin
          if (cnt_q != LEN_W'(0)) begin
            rdata_d = rd_word_s;
          end else begin
            rdata_d = rdata_q;
          end
          cnt_d = nxt_s;
          if (nxt_s < len_q) begin
            mem_a_d = mem_a_q + 32'd1;
          end else begin
            mem_a_d = mem_a_q;
          end
        end
      end
      // mem_wr_q low means the current byte is still waiting on the IO FIFO.
      S_WRITE: begin
        if (mem_wr_q) begin
          if (nxt_s == len_q) begin
            state_d  = S_IDLE;
            mem_wr_d = 1'b0;
            lat_v_d  = 1'b0;
          end else begin
            cnt_d      = nxt_s;
            mem_a_d    = mem_a_q + 32'd1;
            mem_dout_d = byte_sel(lat_dt_q, nxt_s);
            mem_wr_d   = !stall_s;
          end
        end else begin
          mem_wr_d = !stall_s;
        end
      end
      default: begin
        state_d  = S_IDLE;
        mem_wr_d = 1'b0;
      end
    endcase
  end

  // State registers; rdy low freezes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;        cnt_q      <= '0;           len_q      <= '0;
      own_dc_q   <= 1'b0;          last_dc_q  <= 1'b1;         lat_v_q    <= 1'b0;
      lat_ls_q   <= 1'b0;          lat_nick_q <= '0;           lat_len_q  <= '0;
      lat_addr_q <= 32'h0000_0000; lat_dt_q   <= 32'h0000_0000;
      rdata_q    <= 32'h0000_0000; mem_a_q    <= 32'h0000_0000;
      mem_dout_q <= 8'h00;         mem_wr_q   <= 1'b0;
      oif_en_q   <= 1'b0;          oif_dt_q   <= 32'h0000_0000;
      odc_en_q   <= 1'b0;          odc_nick_q <= '0;           odc_dt_q   <= 32'h0000_0000;
    end else if (rdy) begin
      state_q    <= state_d;       cnt_q      <= cnt_d;        len_q      <= len_d;
      own_dc_q   <= own_dc_d;      last_dc_q  <= last_dc_d;    lat_v_q    <= lat_v_d;
      lat_ls_q   <= lat_ls_d;      lat_nick_q <= lat_nick_d;   lat_len_q  <= lat_len_d;
      lat_addr_q <= lat_addr_d;    lat_dt_q   <= lat_dt_d;
      rdata_q    <= rdata_d;       mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;    mem_wr_q   <= mem_wr_d;
      oif_en_q   <= oif_en_d;      oif_dt_q   <= oif_dt_d;
      odc_en_q   <= odc_en_d;      odc_nick_q <= odc_nick_d;   odc_dt_q   <= odc_dt_d;
    end
  end

  // The data requester must never pulse while the latch is occupied.
  a_no_pulse_when_busy: assert property (@(posedge clk) disable iff (rst)
    (rdy && iDC_en) |-> !lat_v_q);

  assign oIF_en   = oif_en_q;
  assign oIF_dt   = oif_dt_q;
  assign oDC_busy = lat_v_q;
  assign oDC_en   = odc_en_q;
  assign oDC_nick = odc_nick_q;
  assign oDC_dt   = odc_dt_q;
  assign mem_a    = mem_a_q;
  assign mem_dout = mem_dout_q;
  assign mem_wr   = mem_wr_q && rdy;

endmodule
